// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcode/funct
// codes, ALU and mux select encodings, FSM state and instruction classes.
package mips_pkg;

   // Primary opcodes (Instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type function codes (Instruction[5:0])
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_JR    = 6'b001000;

   // ALU operations
   localparam logic [3:0] ALU_ADDU = 4'b0000;
   localparam logic [3:0] ALU_SUBU = 4'b0001;
   localparam logic [3:0] ALU_OR   = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_ADDO = 4'b0100;

   // Immediate extension modes
   localparam logic [1:0] EXT_ZERO  = 2'b00;
   localparam logic [1:0] EXT_SIGN  = 2'b01;
   localparam logic [1:0] EXT_UPPER = 2'b10;

   // Next-PC sources
   localparam logic [1:0] NPC_SEQ    = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      C_R_ALU,
      C_I_ALU,
      C_LUI,
      C_LOAD,
      C_STORE,
      C_BRANCH,
      C_JUMP,
      C_JAL,
      C_JR,
      C_ILLEGAL
   } instr_class_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier. Besides the class it produces the
// ALU-side controls, which the FSM applies from EXEC through WB.
module mc_decode
   import mips_pkg::*;
(
   input  logic [31:0]  i_instr,
   output instr_class_e o_class,
   output logic         o_alu_src,
   output logic [1:0]   o_ext_op,
   output logic [3:0]   o_alu_ctr,
   output logic         o_is_lb
);

   logic [5:0] w_op;
   logic [5:0] w_funct;
   logic       w_unused_fields;

   assign w_op            = i_instr[31:26];
   assign w_funct         = i_instr[5:0];
   // Register/immediate fields only matter to the datapath.
   assign w_unused_fields = ^i_instr[25:6];

   // Opcode/funct lookup; anything not listed stays ILLEGAL.
   always_comb begin
      o_class   = C_ILLEGAL;
      o_alu_src = 1'b0;
      o_ext_op  = EXT_ZERO;
      o_alu_ctr = ALU_ADDU;
      o_is_lb   = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            case (w_funct)
               FN_ADDU: begin o_class = C_R_ALU; o_alu_ctr = ALU_ADDU; end
               FN_SUBU: begin o_class = C_R_ALU; o_alu_ctr = ALU_SUBU; end
               FN_SLT:  begin o_class = C_R_ALU; o_alu_ctr = ALU_SLT;  end
               FN_JR:   o_class = C_JR;
               default: o_class = C_ILLEGAL;
            endcase
         end
         OP_ORI: begin
            o_class = C_I_ALU; o_alu_src = 1'b1; o_ext_op = EXT_ZERO; o_alu_ctr = ALU_OR;
         end
         OP_ADDI: begin
            o_class = C_I_ALU; o_alu_src = 1'b1; o_ext_op = EXT_SIGN; o_alu_ctr = ALU_ADDO;
         end
         // lui: rs is zero in the encoding, so OR with the shifted immediate
         OP_LUI: begin
            o_class = C_LUI; o_alu_src = 1'b1; o_ext_op = EXT_UPPER; o_alu_ctr = ALU_OR;
         end
         OP_LW, OP_LB: begin
            o_class = C_LOAD; o_alu_src = 1'b1; o_ext_op = EXT_SIGN; o_alu_ctr = ALU_ADDU;
            o_is_lb = (w_op == OP_LB);
         end
         OP_SW: begin
            o_class = C_STORE; o_alu_src = 1'b1; o_ext_op = EXT_SIGN; o_alu_ctr = ALU_ADDU;
         end
         // beq compares rs-rt; the sign-extended offset feeds the branch adder
         OP_BEQ: begin
            o_class = C_BRANCH; o_alu_src = 1'b0; o_ext_op = EXT_SIGN; o_alu_ctr = ALU_SUBU;
         end
         OP_J:    o_class = C_JUMP;
         OP_JAL:  o_class = C_JAL;
         default: o_class = C_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with a retired
// instruction counter. Outputs are Moore-style from state plus decoded
// class; all of them are forced low while reset is held.
module mips_mc_ctrl
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Instruction,
   output logic        ir_wr,
   output logic        pc_wr,
   output logic        RegDst,
   output logic        RegWr,
   output logic        ALUSrc,
   output logic        MemWr,
   output logic        MemtoReg,
   output logic        j_sel,
   output logic        jal_sel,
   output logic        lb_sel,
   output logic [1:0]  ExtOp,
   output logic [1:0]  nPC_sel,
   output logic [3:0]  ALUctr,
   output logic        illegal,
   output logic [31:0] instr_cnt,
   output logic [2:0]  o_dbg_state
);

   state_e       r_state;
   state_e       w_next_state;
   logic [31:0]  r_instr_cnt;
   instr_class_e w_class;
   logic         w_alu_src;
   logic [1:0]   w_ext_op;
   logic [3:0]   w_alu_ctr;
   logic         w_is_lb;
   logic         w_retire;

   mc_decode u_decode (
      .i_instr   (Instruction),
      .o_class   (w_class),
      .o_alu_src (w_alu_src),
      .o_ext_op  (w_ext_op),
      .o_alu_ctr (w_alu_ctr),
      .o_is_lb   (w_is_lb)
   );

   // A legal instruction retires on the edge that returns the FSM to FETCH.
   assign w_retire    = (r_state != S_FETCH) && (w_next_state == S_FETCH) &&
                        (w_class != C_ILLEGAL);
   assign instr_cnt   = r_instr_cnt;
   assign o_dbg_state = r_state;

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_FETCH;
      else      r_state <= w_next_state;
   end

   // Retired-instruction counter, wraps naturally at 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_instr_cnt <= '0;
      else if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
   end

   // Next-state and control outputs; ALU-side controls hold from EXEC to WB.
   always_comb begin
      w_next_state = r_state;
      ir_wr    = 1'b0;
      pc_wr    = 1'b0;
      RegDst   = 1'b0;
      RegWr    = 1'b0;
      ALUSrc   = 1'b0;
      MemWr    = 1'b0;
      MemtoReg = 1'b0;
      j_sel    = 1'b0;
      jal_sel  = 1'b0;
      lb_sel   = 1'b0;
      ExtOp    = EXT_ZERO;
      nPC_sel  = NPC_SEQ;
      ALUctr   = ALU_ADDU;
      illegal  = 1'b0;
      if (!rst) begin
         w_next_state = S_FETCH;
      end else begin
         case (r_state)
            S_FETCH: begin
               ir_wr        = 1'b1;
               pc_wr        = 1'b1;
               nPC_sel      = NPC_SEQ;
               w_next_state = S_DECODE;
            end
            S_DECODE: begin
               case (w_class)
                  C_JUMP: begin
                     j_sel = 1'b1; nPC_sel = NPC_JUMP; pc_wr = 1'b1;
                     w_next_state = S_FETCH;
                  end
                  C_JAL: begin
                     j_sel = 1'b1; jal_sel = 1'b1; RegWr = 1'b1;
                     nPC_sel = NPC_JUMP; pc_wr = 1'b1;
                     w_next_state = S_FETCH;
                  end
                  C_JR: begin
                     nPC_sel = NPC_JUMP; pc_wr = 1'b1;
                     w_next_state = S_FETCH;
                  end
                  C_ILLEGAL: begin
                     illegal = 1'b1;
                     w_next_state = S_FETCH;
                  end
                  default: w_next_state = S_EXEC;
               endcase
            end
            S_EXEC: begin
               ALUSrc = w_alu_src;
               ExtOp  = w_ext_op;
               ALUctr = w_alu_ctr;
               case (w_class)
                  // pc_wr with nPC_sel=branch; the datapath mux uses zero to pick the target
                  C_BRANCH: begin
                     nPC_sel = NPC_BRANCH; pc_wr = 1'b1;
                     w_next_state = S_FETCH;
                  end
                  C_LOAD, C_STORE: w_next_state = S_MEM;
                  default:         w_next_state = S_WB;
               endcase
            end
            S_MEM: begin
               ALUSrc = w_alu_src;
               ExtOp  = w_ext_op;
               ALUctr = w_alu_ctr;
               lb_sel = w_is_lb;
               if (w_class == C_STORE) begin
                  MemWr = 1'b1;
                  w_next_state = S_FETCH;
               end else begin
                  w_next_state = S_WB;
               end
            end
            S_WB: begin
               ALUSrc   = w_alu_src;
               ExtOp    = w_ext_op;
               ALUctr   = w_alu_ctr;
               lb_sel   = w_is_lb;
               RegWr    = 1'b1;
               RegDst   = (w_class == C_R_ALU);
               MemtoReg = (w_class == C_LOAD);
               w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: directed and random instruction streams compared
// cycle by cycle against a table-driven reference model.
module tb_mips_mc_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] Instruction;
   logic        ir_wr, pc_wr, RegDst, RegWr, ALUSrc, MemWr, MemtoReg;
   logic        j_sel, jal_sel, lb_sel, illegal;
   logic [1:0]  ExtOp, nPC_sel;
   logic [3:0]  ALUctr;
   logic [31:0] instr_cnt;
   logic [2:0]  o_dbg_state;

   int          n_vec;
   int          n_fail;
   logic [31:0] model_cnt;

   // Instruction kinds known to the model
   localparam int K_ILL = 0, K_ADDU = 1, K_SUBU = 2, K_SLT = 3, K_JR = 4,
                  K_ORI = 5, K_ADDI = 6, K_LUI = 7, K_LW = 8, K_LB = 9,
                  K_SW = 10, K_BEQ = 11, K_J = 12, K_JAL = 13;

   mips_mc_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .Instruction (Instruction),
      .ir_wr       (ir_wr),
      .pc_wr       (pc_wr),
      .RegDst      (RegDst),
      .RegWr       (RegWr),
      .ALUSrc      (ALUSrc),
      .MemWr       (MemWr),
      .MemtoReg    (MemtoReg),
      .j_sel       (j_sel),
      .jal_sel     (jal_sel),
      .lb_sel      (lb_sel),
      .ExtOp       (ExtOp),
      .nPC_sel     (nPC_sel),
      .ALUctr      (ALUctr),
      .illegal     (illegal),
      .instr_cnt   (instr_cnt),
      .o_dbg_state (o_dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int kind_of(input logic [31:0] ins);
      logic [5:0] op;
      logic [5:0] fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'h00) begin
         if (fn == 6'h21) return K_ADDU;
         if (fn == 6'h23) return K_SUBU;
         if (fn == 6'h2A) return K_SLT;
         if (fn == 6'h08) return K_JR;
         return K_ILL;
      end
      case (op)
         6'h0D: return K_ORI;
         6'h08: return K_ADDI;
         6'h0F: return K_LUI;
         6'h23: return K_LW;
         6'h20: return K_LB;
         6'h2B: return K_SW;
         6'h04: return K_BEQ;
         6'h02: return K_J;
         6'h03: return K_JAL;
         default: return K_ILL;
      endcase
   endfunction

   // Cycles from FETCH back to FETCH
   function automatic int len_of(input int k);
      if (k == K_ILL || k == K_J || k == K_JAL || k == K_JR) return 2;
      if (k == K_BEQ) return 3;
      if (k == K_LW || k == K_LB) return 5;
      return 4;
   endfunction

   // Expected output vector for cycle c of an instruction:
   // {state, ir_wr, pc_wr, RegDst, RegWr, ALUSrc, MemWr, MemtoReg,
   //  j_sel, jal_sel, lb_sel, illegal, ExtOp, nPC_sel, ALUctr}
   function automatic logic [21:0] exp_vec(input int k, input int c);
      logic [2:0] st;
      logic irw, pcw, rdst, rwr, asrc, mwr, m2r, js, jals, lbs, ill;
      logic [1:0] ext, npc;
      logic [3:0] ctr;
      logic is_mem, is_load;
      st = 3'd0; irw = 0; pcw = 0; rdst = 0; rwr = 0; asrc = 0; mwr = 0;
      m2r = 0; js = 0; jals = 0; lbs = 0; ill = 0; ext = 2'b00; npc = 2'b00; ctr = 4'b0000;
      is_load = (k == K_LW || k == K_LB);
      is_mem  = is_load || (k == K_SW);
      // phase name from the cycle index
      if (c == 0)      st = 3'd0;
      else if (c == 1) st = 3'd1;
      else if (c == 2) st = 3'd2;
      else if (c == 3) st = is_mem ? 3'd3 : 3'd4;
      else             st = 3'd4;
      if (st == 3'd0) begin
         irw = 1; pcw = 1;
      end else if (st == 3'd1) begin
         if (k == K_J)   begin js = 1; npc = 2'b10; pcw = 1; end
         if (k == K_JAL) begin js = 1; jals = 1; rwr = 1; npc = 2'b10; pcw = 1; end
         if (k == K_JR)  begin npc = 2'b10; pcw = 1; end
         if (k == K_ILL) ill = 1;
      end else begin
         case (k)
            K_ADDU: ctr = 4'b0000;
            K_SUBU: ctr = 4'b0001;
            K_SLT:  ctr = 4'b0011;
            K_ORI:  begin asrc = 1; ext = 2'b00; ctr = 4'b0010; end
            K_ADDI: begin asrc = 1; ext = 2'b01; ctr = 4'b0100; end
            K_LUI:  begin asrc = 1; ext = 2'b10; ctr = 4'b0010; end
            K_LW, K_LB, K_SW: begin asrc = 1; ext = 2'b01; ctr = 4'b0000; end
            K_BEQ:  begin ext = 2'b01; ctr = 4'b0001; end
            default: ;
         endcase
         if (st == 3'd2 && k == K_BEQ) begin npc = 2'b01; pcw = 1; end
         if (st == 3'd3 && k == K_SW) mwr = 1;
         if (st >= 3'd3 && k == K_LB) lbs = 1;
         if (st == 3'd4) begin
            rwr  = 1;
            rdst = (k == K_ADDU || k == K_SUBU || k == K_SLT);
            m2r  = is_load;
         end
      end
      return {st, irw, pcw, rdst, rwr, asrc, mwr, m2r, js, jals, lbs, ill, ext, npc, ctr};
   endfunction

   function automatic logic [21:0] act_vec();
      return {o_dbg_state, ir_wr, pc_wr, RegDst, RegWr, ALUSrc, MemWr, MemtoReg,
              j_sel, jal_sel, lb_sel, illegal, ExtOp, nPC_sel, ALUctr};
   endfunction

   // ---------------- driver ----------------
   // Starts at a negedge with the FSM in FETCH. Checks every cycle of the
   // instruction; stop_at >= 0 returns mid-cycle right after checking that
   // cycle (used for reset injection). A full run ends at the next FETCH
   // negedge and checks the counter there.
   task automatic run_instr(input logic [31:0] ins, input int stop_at);
      int k;
      int n;
      logic [21:0] exp_q[$];
      logic [21:0] e;
      k = kind_of(ins);
      n = len_of(k);
      for (int c = 0; c < n; c++) exp_q.push_back(exp_vec(k, c));
      Instruction = ins;
      for (int c = 0; c < n; c++) begin
         #1;
         e = exp_q.pop_front();
         n_vec++;
         if (act_vec() !== e) begin
            n_fail++;
            $display("FAIL cycle instr=%08h c=%0d got=%06h exp=%06h", ins, c, act_vec(), e);
         end
         if (c == stop_at) return;
         @(negedge clk);
      end
      if (k != K_ILL) model_cnt = model_cnt + 32'd1;
      n_vec++;
      if (instr_cnt !== model_cnt) begin
         n_fail++;
         $display("FAIL instr_cnt after %08h got=%0d exp=%0d", ins, instr_cnt, model_cnt);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      Instruction = 32'h0000_0000;
      model_cnt = '0;
      repeat (3) @(negedge clk);
      #1;
      n_vec++;
      if (act_vec() !== 22'h0 || instr_cnt !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state got=%06h cnt=%0d exp=000000 cnt=0", act_vec(), instr_cnt);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_directed();
      run_instr(32'h0022_1821, -1);  // addu
      run_instr(32'h8C22_0004, -1);  // lw
      run_instr(32'hAC22_0008, -1);  // sw
      run_instr(32'h0C00_0010, -1);  // jal
      run_instr(32'hFC00_0000, -1);  // illegal opcode
      run_instr(32'h8022_0003, -1);  // lb
      run_instr(32'h1022_FFFE, -1);  // beq
      run_instr(32'h03E0_0008, -1);  // jr
      run_instr(32'h0800_0040, -1);  // j
      run_instr(32'h3C01_1234, -1);  // lui
      run_instr(32'h0022_183F, -1);  // R-type with bad funct
   endtask

   // Reset asserted during the MEM cycle of sw, then a normal instruction.
   task automatic test_reset_mid_sw();
      run_instr(32'hAC22_0008, 3);
      rst = 1'b0;
      model_cnt = '0;
      #1;
      n_vec++;
      if (act_vec() !== 22'h0 || instr_cnt !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_sw got=%06h cnt=%0d exp=000000 cnt=0", act_vec(), instr_cnt);
      end
      @(negedge clk);
      rst = 1'b1;
      run_instr(32'h0022_1823, -1);  // subu
   endtask

   task automatic test_random();
      logic [31:0] ins;
      logic [5:0]  ops[10];
      logic [5:0]  fns[4];
      int          r;
      ops = '{6'h0D, 6'h08, 6'h0F, 6'h23, 6'h20, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h00};
      fns = '{6'h21, 6'h23, 6'h2A, 6'h08};
      for (int i = 0; i < 300; i++) begin
         ins = $urandom;
         r = $urandom_range(0, 15);
         if (r < 9)       ins[31:26] = ops[r];
         else if (r < 13) begin ins[31:26] = 6'h00; ins[5:0] = fns[r - 9]; end
         else if (r == 13) ins[31:26] = 6'h00;      // random funct, mostly illegal
         run_instr(ins, -1);
      end
   endtask

   initial begin
      n_vec = 0;
      n_fail = 0;
      test_reset();
      test_directed();
      test_reset_mid_sw();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 clk  input  1  Single system clock; all state updates on rising edge.
REQ-002 rst  input  1  Asynchronous, active-low reset.
REQ-003 Instruction  input  32  Instruction register contents from the datapath; valid from DECODE onward.
REQ-004 ir_wr, pc_wr  output  1 each  Load the instruction register; load the PC.
REQ-005 RegDst, RegWr, ALUSrc, MemWr, MemtoReg, j_sel, jal_sel, lb_sel  output  1 each  Datapath controls.
REQ-006 ExtOp  output  2  Immediate extension: 00 zero, 01 sign, 10 upper (lui).
REQ-007 nPC_sel  output  2  Next PC: 00 PC+4, 01 branch target, 10 jump/jr.
REQ-008 ALUctr  output  4  ALU operation: 0000 addu, 0001 subu, 0010 or, 0011 slt, 0100 add with overflow.
REQ-009 illegal  output  1  One-cycle pulse on an undecodable instruction.
REQ-010 instr_cnt  output  32  Count of retired instructions.

Function
REQ-011 The FSM SHALL have states FETCH, DECODE, EXEC, MEM and WB, with encodings 0 to 4.
REQ-012 FETCH SHALL assert ir_wr, pc_wr and nPC_sel=00, then always go to DECODE.
REQ-013 Supported instructions SHALL be:
- R-type (op 000000) funct: addu 100001, subu 100011, slt 101010, jr 001000.
- I/J opcodes: ori 001101, addi 001000, lui 001111, lw 100011, lb 100000, sw 101011, beq 000100, j 000010, jal 000011.
REQ-014 DECODE SHALL handle jumps and then go to FETCH:
- j: j_sel=1, nPC_sel=10, pc_wr=1.
- jal: the same, plus jal_sel=1 and RegWr=1.
- jr: nPC_sel=10, j_sel=0, pc_wr=1.
REQ-015 DECODE SHALL go to EXEC for all other legal instructions.
REQ-016 On an illegal instruction, DECODE SHALL pulse illegal, assert no write enable, and go to FETCH without incrementing instr_cnt.
REQ-017 EXEC SHALL drive ALUSrc, ExtOp and ALUctr per instruction class.
REQ-018 EXEC for beq SHALL assert ALUctr=0001 and nPC_sel=01, and assert pc_wr only when the datapath zero flag is handled by the datapath mux; then go to FETCH.
REQ-019 EXEC SHALL go to MEM for lw/lb/sw and to WB for ALU-class instructions.
REQ-020 MEM SHALL hold the address controls.
REQ-021 MEM for sw SHALL assert MemWr for exactly one cycle, then go to FETCH.
REQ-022 MEM for lw/lb SHALL go to WB; lb_sel=1 for lb.
REQ-023 WB SHALL assert RegWr for exactly one cycle, then go to FETCH.
REQ-024 WB SHALL set RegDst=1 for R-type and 0 otherwise, and MemtoReg=1 for loads.
REQ-025 Outside their stated cycles, RegWr, MemWr, pc_wr and ir_wr SHALL be 0.
REQ-026 Control outputs SHALL hold their EXEC values through MEM and WB so that datapath paths stay stable.
REQ-027 Latency SHALL be: j/jal/jr 2 cycles, beq 3, sw 4, ALU-class 4, loads 5.
REQ-028 instr_cnt SHALL increment by 1 on each transition into FETCH from a legal instruction, and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-029 While rst=0, the state SHALL be FETCH, instr_cnt 0, and every output 0.
REQ-030 Reset asserted mid-instruction SHALL abort it immediately, with no write strobe asserted.
REQ-031 After rst rises, the first clock edge SHALL perform FETCH.

Structure
REQ-032 A package mips_pkg SHALL hold the opcode/funct constants, ALUctr codes, ExtOp/nPC_sel codes and the state encoding.
REQ-033 A combinational sub-module mc_decode SHALL classify Instruction into its class (R_ALU, I_ALU, LUI, LOAD, STORE, BRANCH, JUMP, JAL, JR, ILLEGAL).
REQ-034 The FSM and counter SHALL reside in mips_mc_ctrl.

Verification
REQ-035 addu 0x00221821: states F,D,E,W; WB shows RegWr=1, RegDst=1, ALUctr=0000; instr_cnt +1.
REQ-036 lw 0x8C220004: 5 cycles; EXEC shows ALUSrc=1, ExtOp=01; WB shows MemtoReg=1, RegDst=0, RegWr=1.
REQ-037 sw 0xAC220008: MemWr=1 only in the MEM cycle; RegWr never 1; 4 cycles.
REQ-038 jal 0x0C000010: DECODE shows j_sel=1, jal_sel=1, RegWr=1, nPC_sel=10, pc_wr=1; FETCH follows.
REQ-039 Illegal 0xFC000000: illegal=1 for one cycle; no RegWr/MemWr; instr_cnt unchanged.
REQ-040 Reset during the MEM cycle of sw: MemWr=0 immediately and state FETCH; next instruction executes normally.
